sseg_scan_driver: RTL

Time-multiplexed driver for a 4-digit common-anode seven-segment display; it is the consumer of the BCD digit values produced by the stopwatch's cascaded BCD counters. It snapshots four BCD digits once per scan frame and lights one digit at a time. It provides decoding, leading-zero blanking, per-digit decimal points and an anti-ghosting guard interval. It sits between the counter chain and the board pins.

---
 rtl/sseg_scan_driver.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode seven-segment scan driver: frame-coherent digit
// snapshot, BCD decode, leading-zero blanking, per-digit dp and anode guard.
module sseg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        display_en,
    input  logic        lzb_en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] guard_q, guard_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      sh_dig_q, sh_dig_d;
    logic [3:0]       sh_dp_q, sh_dp_d;
    logic             sh_lzb_q, sh_lzb_d;
    logic             seg_upd_q, seg_upd_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tick;
    logic             guard_done;
    logic [3:0]       cur_dig;
    logic [3:0]       blank_vec;
    logic             blank_cur;
    logic             slot_visible;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b0111111;
        endcase
        return p;
    endfunction

    always_comb begin
        tick       = (cnt_q == CNT_LAST);
        guard_done = (guard_q == CNT_ONE);

        cnt_d   = tick ? '0 : cnt_q + CNT_ONE;
        idx_d   = tick ? idx_q + 2'd1 : idx_q;

        guard_d = guard_q;
        if (tick) begin
            guard_d = GUARD_LD;
        end else if (guard_q != '0) begin
            guard_d = guard_q - CNT_ONE;
        end

        // Shadow copies refresh only as the scan wraps to digit 0.
        sh_dig_d = sh_dig_q;
        sh_dp_d  = sh_dp_q;
        sh_lzb_d = sh_lzb_q;
        if (tick && idx_q == 2'd3) begin
            sh_dig_d = digits;
            sh_dp_d  = dp_mask;
            sh_lzb_d = lzb_en;
        end

        case (idx_q)
            2'd0:    cur_dig = sh_dig_q[3:0];
            2'd1:    cur_dig = sh_dig_q[7:4];
            2'd2:    cur_dig = sh_dig_q[11:8];
            default: cur_dig = sh_dig_q[15:12];
        endcase

        blank_vec[3] = sh_lzb_q && (sh_dig_q[15:12] == 4'd0);
        blank_vec[2] = blank_vec[3] && (sh_dig_q[11:8] == 4'd0);
        blank_vec[1] = blank_vec[2] && (sh_dig_q[7:4] == 4'd0);
        blank_vec[0] = 1'b0;
        blank_cur    = blank_vec[idx_q];
        slot_visible = !blank_cur || sh_dp_q[idx_q];

        seg_upd_d = tick;
        seg_d     = seg_q;
        dp_d      = dp_q;
        if (seg_upd_q) begin
            seg_d = blank_cur ? 7'b1111111 : bcd_to_seg(cur_dig);
            dp_d  = ~sh_dp_q[idx_q];
        end

        // Anode goes dark on every slot change and relights only at guard expiry.
        an_d = an_q;
        if (tick) begin
            an_d = 4'b1111;
        end else if (guard_done && slot_visible) begin
            an_d = ~(4'b0001 << idx_q);
        end
        if (!display_en) begin
            an_d = 4'b1111;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            guard_q   <= '0;
            idx_q     <= 2'd3;
            sh_dig_q  <= '0;
            sh_dp_q   <= '0;
            sh_lzb_q  <= 1'b0;
            seg_upd_q <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= 7'b1111111;
            dp_q      <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            guard_q   <= guard_d;
            idx_q     <= idx_d;
            sh_dig_q  <= sh_dig_d;
            sh_dp_q   <= sh_dp_d;
            sh_lzb_q  <= sh_lzb_d;
            seg_upd_q <= seg_upd_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
